// File: rtl/usb_rx_data_buffer.sv
`default_nettype none
// ============================================================================
// Module   : usb_rx_data_buffer
// Brief    : Circular byte store behind usb_rx. Bytes of a packet become
//            visible to the reader on DONE and are rolled back on ERROR.
//            Optional feature macro: USB_RX_BUF_ROLLBACK_EN (commit/rollback
//            behaviour). When undefined, every stored byte becomes visible
//            one edge after its store and ERROR is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module usb_rx_data_buffer #(
    parameter int DEPTH = 64,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       rx_packet,
    input  logic [7:0]       rx_packet_data,
    input  logic             store_rx_packet_data,
    input  logic             get_rx_data,
    input  logic             flush,
    output logic [7:0]       rx_data,
    output logic [PTR_W:0]   buffer_occupancy,
    output logic             rx_buf_empty,
    output logic             rx_buf_full,
    output logic             rx_overflow
);

    localparam logic [2:0]     c_pkt_done = 3'b101;
`ifdef USB_RX_BUF_ROLLBACK_EN
    localparam logic [2:0]     c_pkt_error = 3'b100;
`endif
    localparam logic [PTR_W:0] c_depth    = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] c_ptr_one  = (PTR_W + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DROP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   cm_ptr_q, cm_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic [2:0]       rx_prev_q;
    logic [7:0]       mem [DEPTH];

    logic             w_mem_we;
    logic             w_done_evt;
    logic [PTR_W:0]   w_used;
`ifdef USB_RX_BUF_ROLLBACK_EN
    logic             w_err_evt;
`endif

    // Status derived from registered pointers only, so it never glitches.
    assign w_used           = wr_ptr_q - rd_ptr_q;
    assign buffer_occupancy = cm_ptr_q - rd_ptr_q;
    assign rx_buf_empty     = (buffer_occupancy == '0);
    assign rx_buf_full      = (w_used == c_depth);
    assign rx_overflow      = overflow_q;
    assign rx_data          = mem[rd_ptr_q[PTR_W-1:0]];

    assign w_done_evt = (rx_packet == c_pkt_done) && (rx_prev_q != c_pkt_done);
`ifdef USB_RX_BUF_ROLLBACK_EN
    assign w_err_evt  = (rx_packet == c_pkt_error) && (rx_prev_q != c_pkt_error);
`endif

    // Next-state: pointer updates, packet commit/rollback and flush override.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        cm_ptr_d   = cm_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        w_mem_we   = 1'b0;

        if (get_rx_data && !rx_buf_empty) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
        end

`ifdef USB_RX_BUF_ROLLBACK_EN
        case (state_q)
            ST_IDLE, ST_ACTIVE: begin
                if (store_rx_packet_data) begin
                    if (!rx_buf_full) begin
                        w_mem_we = 1'b1;
                        wr_ptr_d = wr_ptr_q + c_ptr_one;
                        state_d  = ST_ACTIVE;
                    end else begin
                        overflow_d = 1'b1;
                        state_d    = ST_DROP;
                    end
                end
                if (w_err_evt) begin
                    wr_ptr_d = cm_ptr_q;
                    state_d  = ST_IDLE;
                end else if (w_done_evt) begin
                    // A packet that lost a byte this very cycle is truncated.
                    if (state_d == ST_DROP) begin
                        wr_ptr_d = cm_ptr_q;
                    end else begin
                        cm_ptr_d = wr_ptr_d;
                    end
                    state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (w_done_evt || w_err_evt) begin
                    wr_ptr_d = cm_ptr_q;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`else
        if (store_rx_packet_data) begin
            if (!rx_buf_full) begin
                w_mem_we = 1'b1;
                wr_ptr_d = wr_ptr_q + c_ptr_one;
                state_d  = ST_ACTIVE;
            end else begin
                overflow_d = 1'b1;
            end
        end
        if (w_done_evt) begin
            state_d = ST_IDLE;
        end
        // Commit boundary trails the write pointer by one edge.
        cm_ptr_d = wr_ptr_q;
`endif

        if (flush) begin
            state_d    = ST_IDLE;
            wr_ptr_d   = '0;
            cm_ptr_d   = '0;
            rd_ptr_d   = '0;
            overflow_d = 1'b0;
            w_mem_we   = 1'b0;
        end
    end

    // State and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            cm_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            rx_prev_q  <= 3'b000;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            cm_ptr_q   <= cm_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            rx_prev_q  <= rx_packet;
        end
    end

    // Byte storage; contents beyond the pointers are don't-care, so no reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem[wr_ptr_q[PTR_W-1:0]] <= rx_packet_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_data_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_rx_data_buffer
// Brief    : Directed self-checking bench for usb_rx_data_buffer with a byte
//            scoreboard. Expectations follow USB_RX_BUF_ROLLBACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_rx_data_buffer;

    localparam int DEPTH = 64;
    localparam int PTR_W = $clog2(DEPTH);
`ifdef USB_RX_BUF_ROLLBACK_EN
    localparam bit ROLLBACK = 1'b1;
`else
    localparam bit ROLLBACK = 1'b0;
`endif
    localparam logic [2:0] c_idle = 3'b000;
    localparam logic [2:0] c_err  = 3'b100;
    localparam logic [2:0] c_done = 3'b101;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       rx_packet;
    logic [7:0]       rx_packet_data;
    logic             store_rx_packet_data;
    logic             get_rx_data;
    logic             flush;
    logic [7:0]       rx_data;
    logic [PTR_W:0]   buffer_occupancy;
    logic             rx_buf_empty;
    logic             rx_buf_full;
    logic             rx_overflow;

    int               n_cmp = 0;
    int               n_err = 0;
    logic [7:0]       sb[$];

    usb_rx_data_buffer #(.DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .rx_packet            (rx_packet),
        .rx_packet_data       (rx_packet_data),
        .store_rx_packet_data (store_rx_packet_data),
        .get_rx_data          (get_rx_data),
        .flush                (flush),
        .rx_data              (rx_data),
        .buffer_occupancy     (buffer_occupancy),
        .rx_buf_empty         (rx_buf_empty),
        .rx_buf_full          (rx_buf_full),
        .rx_overflow          (rx_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        store_rx_packet_data = 1'b0;
        get_rx_data          = 1'b0;
        flush                = 1'b0;
    endtask

    task automatic do_store(input logic [7:0] b);
        rx_packet_data       = b;
        store_rx_packet_data = 1'b1;
        step();
    endtask

    task automatic pop_chk(input string tag);
        logic [7:0] e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: observed pop expected empty scoreboard", tag);
        end else begin
            e = sb.pop_front();
            chk(tag, {24'h0, rx_data}, {24'h0, e});
            get_rx_data = 1'b1;
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        rx_packet = c_idle;
        rx_packet_data = 8'h00;
        store_rx_packet_data = 1'b0;
        get_rx_data = 1'b0;
        flush = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_occ",   32'(buffer_occupancy), 32'd0);
        chk("rst_empty", 32'(rx_buf_empty), 32'd1);
        chk("rst_full",  32'(rx_buf_full), 32'd0);
        chk("rst_ovf",   32'(rx_overflow), 32'd0);

        // Two bytes, DONE held for five cycles
        do_store(8'hAF); sb.push_back(8'hAF);
        chk("p1_occ_a", 32'(buffer_occupancy), 32'd0);
        do_store(8'hDD); sb.push_back(8'hDD);
        chk("p1_occ_b", 32'(buffer_occupancy), ROLLBACK ? 32'd0 : 32'd1);
        rx_packet = c_done;
        step();
        chk("p1_occ_done", 32'(buffer_occupancy), 32'd2);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("p1_occ_hold", 32'(buffer_occupancy), 32'd2);
        end
        rx_packet = c_idle;
        step();
        pop_chk("p1_pop0");
        pop_chk("p1_pop1");
        chk("p1_empty", 32'(rx_buf_empty), 32'd1);

        // Committed byte, then a packet ending in ERROR, then another packet
        do_store(8'h11); sb.push_back(8'h11);
        rx_packet = c_done; step();
        rx_packet = c_idle; step();
        do_store(8'h22);
        do_store(8'h33);
        if (!ROLLBACK) begin
            sb.push_back(8'h22);
            sb.push_back(8'h33);
        end
        rx_packet = c_err; step();
        rx_packet = c_idle; step();
        chk("p2_occ_err", 32'(buffer_occupancy), ROLLBACK ? 32'd1 : 32'd3);
        do_store(8'h44); sb.push_back(8'h44);
        rx_packet = c_done; step();
        rx_packet = c_idle; step();
        chk("p2_occ_done", 32'(buffer_occupancy), ROLLBACK ? 32'd2 : 32'd4);
        while (sb.size() != 0) pop_chk("p2_pop");
        chk("p2_empty", 32'(rx_buf_empty), 32'd1);

        // Fill to capacity and one more
        for (int i = 0; i < DEPTH; i++) begin
            do_store(8'(i) ^ 8'h5A);
            if (!ROLLBACK) sb.push_back(8'(i) ^ 8'h5A);
        end
        chk("ov_full64", 32'(rx_buf_full), 32'd1);
        chk("ov_ovf64",  32'(rx_overflow), 32'd0);
        do_store(8'hEE);
        chk("ov_ovf65",  32'(rx_overflow), 32'd1);
        chk("ov_occ65",  32'(buffer_occupancy), ROLLBACK ? 32'd0 : 32'(DEPTH));
        rx_packet = c_done; step();
        rx_packet = c_idle; step();
        chk("ov_occ_done",  32'(buffer_occupancy), ROLLBACK ? 32'd0 : 32'(DEPTH));
        chk("ov_full_done", 32'(rx_buf_full), ROLLBACK ? 32'd0 : 32'd1);
        while (sb.size() != 0) pop_chk("ov_pop");
        chk("ov_empty", 32'(rx_buf_empty), 32'd1);
        chk("ov_sticky", 32'(rx_overflow), 32'd1);
        flush = 1'b1; step();
        chk("ov_flush_ovf", 32'(rx_overflow), 32'd0);
        chk("ov_flush_occ", 32'(buffer_occupancy), 32'd0);

        // Pop when empty is ignored
        get_rx_data = 1'b1; step();
        chk("ep_occ",   32'(buffer_occupancy), 32'd0);
        chk("ep_empty", 32'(rx_buf_empty), 32'd1);

        // Simultaneous store and pop with three committed bytes
        do_store(8'hA1); sb.push_back(8'hA1);
        do_store(8'hA2); sb.push_back(8'hA2);
        do_store(8'hA3); sb.push_back(8'hA3);
        rx_packet = c_done; step();
        rx_packet = c_idle; step();
        chk("sp_occ3", 32'(buffer_occupancy), 32'd3);
        chk("sp_head", 32'(rx_data), 32'(sb.pop_front()));
        rx_packet_data = 8'hB4;
        store_rx_packet_data = 1'b1;
        get_rx_data = 1'b1;
        sb.push_back(8'hB4);
        step();
        rx_packet = c_done; step();
        rx_packet = c_idle; step();
        chk("sp_occ_after", 32'(buffer_occupancy), 32'd3);
        chk("sp_head2", 32'(rx_data), 32'(sb[0]));
        rx_packet_data = 8'hC5;
        store_rx_packet_data = 1'b1;
        flush = 1'b1;
        step();
        sb.delete();
        chk("fl_occ",   32'(buffer_occupancy), 32'd0);
        chk("fl_empty", 32'(rx_buf_empty), 32'd1);
        chk("fl_ovf",   32'(rx_overflow), 32'd0);
        step();
        chk("fl_occ_late", 32'(buffer_occupancy), 32'd0);

        // Store followed by ERROR
        do_store(8'h77);
        chk("se_occ_store", 32'(buffer_occupancy), 32'd0);
        rx_packet = c_err; step();
        chk("se_occ_err", 32'(buffer_occupancy), ROLLBACK ? 32'd0 : 32'd1);
        rx_packet = c_idle; step();
        chk("se_occ_late", 32'(buffer_occupancy), ROLLBACK ? 32'd0 : 32'd1);
        if (!ROLLBACK) begin
            sb.push_back(8'h77);
            pop_chk("se_pop");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
